minitb_ahb_arbiter: RTL and testbench

- Round-robin bus arbiter that shares one AHB-lite slave port between NUM_MASTERS testbench masters.
- Grants the address phase to one master at a time and muxes that master's address and control onto the slave.
- Tracks the data-phase owner separately, so it routes hwdata and hready/hrdata correctly across pipelined ownership changes.
- Sits between minitb master BFMs and the DUT slave port.

---
 rtl/minitb_ahb_arbiter_pkg.sv | 27 ++
 rtl/minitb_ahb_arbiter_if.sv | 34 +++
 rtl/minitb_ahb_arbiter_rr_picker.sv | 25 ++
 rtl/minitb_ahb_arbiter.sv | 127 ++++++++++++
 tb/tb_minitb_ahb_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/minitb_ahb_arbiter_pkg.sv
// Shared constants and types for the minitb AHB-lite round-robin arbiter.
package minitb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Wide enough for 8 masters plus a sentinel that never collides with a real index.
    typedef logic [3:0] owner_t;
    localparam owner_t NO_OWNER = 4'hF;

    typedef logic [3:0] qcnt_t;

    typedef enum logic {
        ST_NO_OWNER = 1'b0,
        ST_OWNED    = 1'b1
    } arb_state_t;

    function automatic owner_t wrap_add(input owner_t base, input int off, input int n);
        int s;
        s = int'(base) + off;
        if (s >= n) s = s - n;
        return owner_t'(s);
    endfunction

endpackage

// File: rtl/minitb_ahb_arbiter_if.sv
// Master-side and slave-side AHB-lite signals around the arbiter.
// Valid/ready: an address phase on s_htrans is accepted at a posedge only when s_hready=1;
// a master whose m_hready is low must hold its address/control unchanged.
interface minitb_ahb_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]                 m_hbusreq;
    logic [NUM_MASTERS-1:0]                 m_hgrant;
    logic [NUM_MASTERS-1:0][1:0]            m_htrans;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_haddr;
    logic [NUM_MASTERS-1:0]                 m_hwrite;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_hwdata;
    logic [NUM_MASTERS-1:0]                 m_hready;
    logic [DATA_WIDTH-1:0]                  m_hrdata;
    logic [1:0]                             s_htrans;
    logic [ADDR_WIDTH-1:0]                  s_haddr;
    logic                                   s_hwrite;
    logic [DATA_WIDTH-1:0]                  s_hwdata;
    logic                                   s_hready;
    logic [DATA_WIDTH-1:0]                  s_hrdata;

    // The arbiter is the slave of the requesting masters and drives the shared slave port.
    modport slave (
        input  m_hbusreq, m_htrans, m_haddr, m_hwrite, m_hwdata, s_hready, s_hrdata,
        output m_hgrant, m_hready, m_hrdata, s_htrans, s_haddr, s_hwrite, s_hwdata
    );

    modport master (
        output m_hbusreq, m_htrans, m_haddr, m_hwrite, m_hwdata, s_hready, s_hrdata,
        input  m_hgrant, m_hready, m_hrdata, s_htrans, s_haddr, s_hwrite, s_hwdata
    );
endinterface

// File: rtl/minitb_ahb_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after ptr, wrapping.
module minitb_rr_picker
    import minitb_ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  owner_t                 ptr,
    output logic                   valid,
    output owner_t                 idx
);
    logic [2*NUM_MASTERS-1:0] doubled;
    logic [NUM_MASTERS-1:0]   rotated;

    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[NUM_MASTERS-1:0];
        valid   = |req;
        idx     = NO_OWNER;
        // Walk downward so the smallest offset from ptr wins.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (rotated[k]) idx = wrap_add(ptr, k, NUM_MASTERS);
        end
    end
endmodule

// File: rtl/minitb_ahb_arbiter.sv
// Round-robin AHB-lite arbiter with a per-tenure NONSEQ quantum and a separate
// data-phase owner so write data and hready follow pipelined ownership changes.
module minitb_ahb_arbiter
    import minitb_ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int QUANTUM     = 4
) (
    input  logic                hclk,
    input  logic                hreset,
    minitb_ahb_arbiter_if.slave bus,
    output arb_state_t          state
);
    localparam qcnt_t QMAX = qcnt_t'(QUANTUM);

    arb_state_t             state_n;
    owner_t                 addr_owner, addr_owner_n;
    owner_t                 data_owner, data_owner_n;
    owner_t                 rr_ptr, rr_ptr_n;
    owner_t                 pick_idx;
    qcnt_t                  quantum_cnt, quantum_cnt_n, cnt_inc;
    logic [NUM_MASTERS-1:0] grant, grant_n, owner_mask, others;
    logic                   pick_valid, owner_req, take, drop, nonseq;
    logic [ADDR_WIDTH-1:0]  haddr_sel;
    logic [DATA_WIDTH-1:0]  hwdata_sel;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state       <= ST_NO_OWNER;
            addr_owner  <= NO_OWNER;
            data_owner  <= NO_OWNER;
            rr_ptr      <= '0;
            quantum_cnt <= '0;
            grant       <= '0;
        end else begin
            state       <= state_n;
            addr_owner  <= addr_owner_n;
            data_owner  <= data_owner_n;
            rr_ptr      <= rr_ptr_n;
            quantum_cnt <= quantum_cnt_n;
            grant       <= grant_n;
        end
    end

    // Candidates for the next tenure exclude the current owner.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) owner_mask[i] = (addr_owner == owner_t'(i));
        others    = bus.m_hbusreq & ~owner_mask;
        owner_req = |(bus.m_hbusreq & owner_mask);
        nonseq    = (bus.s_htrans == HTRANS_NONSEQ);
    end

    minitb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
        .req   (others),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_n       = state;
        addr_owner_n  = addr_owner;
        data_owner_n  = data_owner;
        rr_ptr_n      = rr_ptr;
        quantum_cnt_n = quantum_cnt;
        grant_n       = grant;
        take          = 1'b0;
        drop          = 1'b0;
        cnt_inc       = quantum_cnt;
        if (nonseq && quantum_cnt < QMAX) cnt_inc = quantum_cnt + 4'd1;
        if (bus.s_hready) begin
            data_owner_n  = nonseq ? addr_owner : NO_OWNER;
            quantum_cnt_n = cnt_inc;
            case (state)
                ST_NO_OWNER: take = pick_valid;
                ST_OWNED: begin
                    if (!owner_req && bus.s_htrans == HTRANS_IDLE) begin
                        take = pick_valid;
                        drop = !pick_valid;
                    end else if (cnt_inc >= QMAX && pick_valid) begin
                        take = 1'b1;
                    end
                end
                default: drop = 1'b1;
            endcase
            if (take) begin
                state_n       = ST_OWNED;
                addr_owner_n  = pick_idx;
                rr_ptr_n      = wrap_add(pick_idx, 1, NUM_MASTERS);
                quantum_cnt_n = '0;
                for (int i = 0; i < NUM_MASTERS; i++) grant_n[i] = (pick_idx == owner_t'(i));
            end else if (drop) begin
                state_n       = ST_NO_OWNER;
                addr_owner_n  = NO_OWNER;
                quantum_cnt_n = '0;
                grant_n       = '0;
            end
        end
    end

    // Non-owners are held off while anyone requests so their address phase stalls.
    always_comb begin
        bus.s_htrans = HTRANS_IDLE;
        bus.s_hwrite = 1'b0;
        bus.m_hready = '0;
        haddr_sel    = '0;
        hwdata_sel   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (addr_owner == owner_t'(i)) begin
                bus.s_htrans = bus.m_htrans[i];
                bus.s_hwrite = bus.m_hwrite[i];
                haddr_sel    = bus.m_haddr[i];
            end
            if (data_owner == owner_t'(i)) hwdata_sel = bus.m_hwdata[i];
            if (addr_owner == owner_t'(i) || data_owner == owner_t'(i))
                bus.m_hready[i] = bus.s_hready;
            else
                bus.m_hready[i] = (|bus.m_hbusreq) ? 1'b0 : bus.s_hready;
        end
        bus.s_haddr  = haddr_sel;
        bus.s_hwdata = hwdata_sel;
        bus.m_hgrant = grant;
        bus.m_hrdata = bus.s_hrdata;
    end
endmodule

// File: tb/tb_minitb_ahb_arbiter.sv
// Directed bench for minitb_ahb_arbiter: two masters, QUANTUM=4, hand-computed expectations.
module tb_minitb_ahb_arbiter;
    import minitb_ahb_pkg::*;

    logic       hclk = 1'b0;
    logic       hreset;
    arb_state_t state;
    int         vectors = 0;
    int         miscompares = 0;

    minitb_ahb_arbiter_if #(.NUM_MASTERS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    minitb_ahb_arbiter #(
        .NUM_MASTERS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .QUANTUM(4)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus),
        .state  (state)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_grant[12];
    logic [7:0] exp_addr[12];

    initial begin
        exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01,
                      2'b10, 2'b10, 2'b10, 2'b10};
        exp_addr  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h40, 8'h40, 8'h40, 8'h40,
                      8'h80, 8'h80, 8'h80, 8'h80};

        hreset        = 1'b1;
        bus.m_hbusreq = '0;
        bus.m_htrans  = '0;
        bus.m_haddr   = '0;
        bus.m_hwrite  = '0;
        bus.m_hwdata  = '0;
        bus.s_hready  = 1'b1;
        bus.s_hrdata  = '0;
        #1;
        check("rst_grant", bus.m_hgrant, 2'b00);
        check("rst_htrans", bus.s_htrans, HTRANS_IDLE);
        check("rst_haddr", bus.s_haddr, 8'h00);
        check("rst_hwdata", bus.s_hwdata, 32'h0);
        check("rst_state", state, ST_NO_OWNER);
        step();
        hreset = 1'b0;

        // Single master write
        bus.m_hbusreq = 2'b01;
        bus.m_haddr[0] = 8'h10;
        bus.m_hwrite[0] = 1'b1;
        step();
        check("single_grant", bus.m_hgrant, 2'b01);
        check("single_state", state, ST_OWNED);
        check("single_hready", bus.m_hready, 2'b01);
        bus.m_htrans[0] = HTRANS_NONSEQ;
        #1;
        check("single_htrans", bus.s_htrans, HTRANS_NONSEQ);
        check("single_haddr", bus.s_haddr, 8'h10);
        check("single_hwrite", bus.s_hwrite, 1'b1);
        step();
        bus.m_hwdata[0] = 32'hDEADBEEF;
        bus.m_htrans[0] = HTRANS_IDLE;
        bus.m_hbusreq = 2'b00;
        #1;
        check("single_hwdata", bus.s_hwdata, 32'hDEADBEEF);
        step();
        check("release_grant", bus.m_hgrant, 2'b00);
        check("release_state", state, ST_NO_OWNER);
        check("release_hwdata", bus.s_hwdata, 32'h0);

        // Both masters streaming NONSEQ; rr_ptr now points at master 1
        bus.m_hbusreq = 2'b11;
        bus.m_htrans[0] = HTRANS_NONSEQ;
        bus.m_htrans[1] = HTRANS_NONSEQ;
        bus.m_haddr[0] = 8'h40;
        bus.m_haddr[1] = 8'h80;
        bus.m_hwrite = 2'b00;
        for (int e = 0; e < 12; e++) begin
            step();
            check($sformatf("quantum_grant_e%0d", e + 1), bus.m_hgrant, exp_grant[e]);
            check($sformatf("quantum_haddr_e%0d", e + 1), bus.s_haddr, exp_addr[e]);
        end

        // Slave stall while master 1 has reached 3 of 4 transfers and master 0 waits
        bus.s_hready = 1'b0;
        bus.m_hwdata[0] = 32'h11111111;
        bus.m_hwdata[1] = 32'hCAFEF00D;
        #1;
        check("stall_hwdata0", bus.s_hwdata, 32'hCAFEF00D);
        check("stall_hready", bus.m_hready, 2'b00);
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("stall_grant_%0d", s), bus.m_hgrant, 2'b10);
            check($sformatf("stall_haddr_%0d", s), bus.s_haddr, 8'h80);
            check($sformatf("stall_hwdata_%0d", s), bus.s_hwdata, 32'hCAFEF00D);
        end
        bus.s_hready = 1'b1;
        step();
        check("unstall_grant", bus.m_hgrant, 2'b01);
        check("unstall_haddr", bus.s_haddr, 8'h40);
        check("unstall_hwdata", bus.s_hwdata, 32'hCAFEF00D);
        check("unstall_hready", bus.m_hready, 2'b11);

        // No requests: release within one edge
        bus.m_hbusreq = 2'b00;
        bus.m_htrans = '0;
        step();
        check("idle_grant", bus.m_hgrant, 2'b00);
        check("idle_htrans", bus.s_htrans, HTRANS_IDLE);
        check("idle_state", state, ST_NO_OWNER);
        check("idle_hwdata", bus.s_hwdata, 32'h0);

        // Pipelined handover: master 0 write 0x20, master 1 read 0x30
        bus.m_hbusreq = 2'b01;
        step();
        check("ho_grant0", bus.m_hgrant, 2'b01);
        bus.m_hbusreq = 2'b11;
        bus.m_htrans[0] = HTRANS_NONSEQ;
        bus.m_haddr[0] = 8'h20;
        bus.m_hwrite[0] = 1'b1;
        bus.m_hwdata[0] = 32'hA5A50020;
        bus.m_htrans[1] = HTRANS_NONSEQ;
        bus.m_haddr[1] = 8'h30;
        bus.m_hwrite[1] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            check($sformatf("ho_hold_%0d", t), bus.m_hgrant, 2'b01);
        end
        step();
        check("ho_grant1", bus.m_hgrant, 2'b10);
        check("ho_haddr", bus.s_haddr, 8'h30);
        check("ho_hwrite", bus.s_hwrite, 1'b0);
        check("ho_hwdata", bus.s_hwdata, 32'hA5A50020);
        check("ho_hready", bus.m_hready, 2'b11);
        bus.s_hrdata = 32'h12345678;
        step();
        check("ho_hrdata", bus.m_hrdata, 32'h12345678);
        check("ho_hready_rd", bus.m_hready, 2'b10);
        check("ho_grant_keep", bus.m_hgrant, 2'b10);

        // Asynchronous reset mid-transfer
        #2;
        hreset = 1'b1;
        #1;
        check("arst_grant", bus.m_hgrant, 2'b00);
        check("arst_htrans", bus.s_htrans, HTRANS_IDLE);
        check("arst_hwdata", bus.s_hwdata, 32'h0);
        check("arst_state", state, ST_NO_OWNER);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
